// File: rtl/ar_rx_sched_if.sv
// Shared write port from the receive scheduler into the label mailbox.
interface ar_rx_sched_if #(parameter int CHW = 3);
  logic           wr_en;
  logic           wr_rdy;
  logic [CHW-1:0] wr_ch;
  logic [7:0]     wr_lbl;
  logic [22:0]    wr_dat;

  modport master (output wr_en, wr_ch, wr_lbl, wr_dat, input wr_rdy);
  modport slave  (input wr_en, wr_ch, wr_lbl, wr_dat, output wr_rdy);
endinterface

// File: rtl/ar_rx_sched.sv
// ARINC-429 receive scheduler: per-channel capture and label filter,
// round-robin arbitration onto one valid/ready port, overrun and link-loss
// status, saturating count of filtered words.

// One receive channel: holding register, overrun flag, link monitor.
module ar_rx_lane #(parameter logic [15:0] LIM = 16'd60000) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_wr_i,
  input  logic        acc_i,      // label-table entry for this word
  input  logic        gnt_i,      // arbiter takes the held word this cycle
  input  logic        ovr_clr_i,
  input  logic [30:0] word_i,
  output logic        hv_o,
  output logic        ovr_o,
  output logic        lost_o,
  output logic        rej_o,
  output logic [30:0] hold_o
);
  logic        cap;
  logic        hv_q, hv_d, ovr_q, ovr_d, lost_q, lost_d;
  logic [15:0] cnt_q, cnt_d;
  logic [30:0] hold_q;

  assign cap    = rx_wr_i & acc_i;
  assign rej_o  = rx_wr_i & ~acc_i;
  assign hv_o   = hv_q;
  assign ovr_o  = ovr_q;
  assign lost_o = lost_q;
  assign hold_o = hold_q;

  // Next state: a grant empties the holder first, a capture refills it;
  // overwriting an ungranted word is an overrun, and a set beats a clear.
  // lost drops in the strobe cycle itself so it falls one cycle after rx_wr.
  always_comb begin
    hv_d = hv_q;
    if (gnt_i) hv_d = 1'b0;
    if (cap)   hv_d = 1'b1;
    ovr_d = ovr_q & ~ovr_clr_i;
    if (cap && hv_q && !gnt_i) ovr_d = 1'b1;
    cnt_d  = rx_wr_i ? 16'd0 : ((cnt_q == LIM) ? cnt_q : cnt_q + 16'd1);
    lost_d = !rx_wr_i && (cnt_q == LIM);
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hv_q   <= 1'b0;
      ovr_q  <= 1'b0;
      lost_q <= 1'b0;
      cnt_q  <= '0;
      hold_q <= '0;
    end else begin
      hv_q   <= hv_d;
      ovr_q  <= ovr_d;
      lost_q <= lost_d;
      cnt_q  <= cnt_d;
      if (cap) hold_q <= word_i;
    end
  end
endmodule

module ar_rx_sched #(
  parameter int NCH      = 4,
  parameter int CHW      = 3,
  parameter int LOST_LIM = 60000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH*8-1:0]  rx_adr,
  input  logic [NCH*23-1:0] rx_dat,
  input  logic [NCH-1:0]    rx_wr,
  input  logic              cfg_we,
  input  logic [7:0]        cfg_lbl,
  input  logic              cfg_en,
  ar_rx_sched_if.master     wr,
  output logic [NCH-1:0]    ovr,
  input  logic [NCH-1:0]    ovr_clr,
  output logic [NCH-1:0]    lost,
  output logic [15:0]       drop_cnt
);
  typedef enum logic {IDLE, ISSUE} st_t;
  st_t st_q, st_d;

  logic [255:0]            tbl_q;
  logic [NCH-1:0]          hv, rej, acc, gnt;
  logic [NCH-1:0][30:0]    hold;
  logic [(1<<CHW)-1:0]     hv_x;
  logic [CHW-1:0]          ptr_q, gsel, c;
  logic                    found, ld;
  logic [30:0]             gword;
  logic [CHW-1:0]          wr_ch_q;
  logic [30:0]             wr_word_q;
  logic [15:0]             drop_q, drop_d;
  logic [3:0]              nrej;
  logic [16:0]             drop_sum;

  for (genvar k = 0; k < NCH; k++) begin : g_lane
    assign acc[k] = tbl_q[rx_adr[8*k +: 8]];
    assign gnt[k] = ld && (gsel == CHW'(k));
    ar_rx_lane #(.LIM(16'(LOST_LIM))) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx_wr_i   (rx_wr[k]),
      .acc_i     (acc[k]),
      .gnt_i     (gnt[k]),
      .ovr_clr_i (ovr_clr[k]),
      .word_i    ({rx_adr[8*k +: 8], rx_dat[23*k +: 23]}),
      .hv_o      (hv[k]),
      .ovr_o     (ovr[k]),
      .lost_o    (lost[k]),
      .rej_o     (rej[k]),
      .hold_o    (hold[k])
    );
  end

  // Round-robin search: first valid channel strictly after ptr, wrapping.
  always_comb begin
    hv_x = '0;
    hv_x[NCH-1:0] = hv;
    found = 1'b0;
    gsel  = ptr_q;
    c     = ptr_q;
    for (int i = 0; i < NCH; i++) begin
      c = (c == CHW'(NCH-1)) ? '0 : c + CHW'(1);
      if (!found && hv_x[c]) begin
        found = 1'b1;
        gsel  = c;
      end
    end
  end

  // Word of the channel being granted.
  always_comb begin
    gword = '0;
    for (int k = 0; k < NCH; k++)
      if (gsel == CHW'(k)) gword = hold[k];
  end

  // Arbiter next state: grant from IDLE, hold the word in ISSUE until taken.
  always_comb begin
    st_d = st_q;
    ld   = 1'b0;
    case (st_q)
      IDLE:  if (found) begin ld = 1'b1; st_d = ISSUE; end
      ISSUE: if (wr.wr_rdy) st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  // Arbiter state, round-robin pointer and output word registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= IDLE;
      ptr_q     <= CHW'(NCH-1);
      wr_ch_q   <= '0;
      wr_word_q <= '0;
    end else begin
      st_q <= st_d;
      if (ld) begin
        ptr_q     <= gsel;
        wr_ch_q   <= gsel;
        wr_word_q <= gword;
      end
    end
  end

  // Rejected words this cycle, added with saturation.
  always_comb begin
    nrej = '0;
    for (int k = 0; k < NCH; k++) nrej = nrej + {3'b000, rej[k]};
    drop_sum = {1'b0, drop_q} + {13'd0, nrej};
    drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  // Label table (captures this cycle see the old entry) and drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl_q  <= '1;
      drop_q <= '0;
    end else begin
      if (cfg_we) tbl_q[cfg_lbl] <= cfg_en;
      drop_q <= drop_d;
    end
  end

  assign wr.wr_en  = (st_q == ISSUE);
  assign wr.wr_ch  = wr_ch_q;
  assign wr.wr_lbl = wr_word_q[30:23];
  assign wr.wr_dat = wr_word_q[22:0];
  assign drop_cnt  = drop_q;
endmodule

// File: tb/tb_ar_rx_sched.sv
// Bench for ar_rx_sched: directed scenarios plus random traffic, checked
// against a word-level reference model through an expected-word queue.
module tb_ar_rx_sched;
  localparam int NCH = 4, CHW = 3, LIM = 10;

  logic              clk = 1'b0, rst_n = 1'b0;
  logic [NCH*8-1:0]  rx_adr = '0;
  logic [NCH*23-1:0] rx_dat = '0;
  logic [NCH-1:0]    rx_wr = '0, ovr_clr = '0, ovr, lost;
  logic              cfg_we = 1'b0, cfg_en = 1'b0;
  logic [7:0]        cfg_lbl = '0;
  logic [15:0]       drop_cnt;

  always #5 clk = ~clk;

  ar_rx_sched_if #(.CHW(CHW)) wif();

  ar_rx_sched #(.NCH(NCH), .CHW(CHW), .LOST_LIM(LIM)) dut (
    .clk(clk), .rst_n(rst_n), .rx_adr(rx_adr), .rx_dat(rx_dat), .rx_wr(rx_wr),
    .cfg_we(cfg_we), .cfg_lbl(cfg_lbl), .cfg_en(cfg_en), .wr(wif),
    .ovr(ovr), .ovr_clr(ovr_clr), .lost(lost), .drop_cnt(drop_cnt));

  int total = 0, bad = 0, ndeliv = 0;

  typedef struct { int ch; logic [7:0] lbl; logic [22:0] dat; } wd_t;
  wd_t exq[$];

  // Reference model: one pending word per channel, a busy output slot,
  // and cycles-since-last-strobe per channel.
  bit             mtbl [256];
  bit             mpv  [NCH];
  logic [30:0]    mpw  [NCH];
  int             midle[NCH];
  int             mptr, mdrop;
  bit             mbusy;
  logic [NCH-1:0] movr;

  function automatic void model_reset();
    foreach (mtbl[i]) mtbl[i] = 1'b1;
    for (int k = 0; k < NCH; k++) begin mpv[k] = 0; mpw[k] = '0; midle[k] = 0; end
    mptr = NCH - 1; mdrop = 0; mbusy = 0; movr = '0;
    exq.delete();
  endfunction

  function automatic void model_step();
    int g, ndrop;
    logic [7:0] lb;
    wd_t w;
    g = -1; ndrop = 0;
    if (!mbusy)
      for (int i = 1; i <= NCH; i++)
        if (g < 0 && mpv[(mptr + i) % NCH]) g = (mptr + i) % NCH;
    if (mbusy && wif.wr_rdy) mbusy = 0;
    if (g >= 0) begin
      w.ch = g; w.lbl = mpw[g][30:23]; w.dat = mpw[g][22:0];
      exq.push_back(w);
      mbusy = 1; mptr = g; mpv[g] = 0;
    end
    movr = movr & ~ovr_clr;
    for (int k = 0; k < NCH; k++) begin
      if (rx_wr[k]) begin
        midle[k] = 0;
        lb = rx_adr[8*k +: 8];
        if (mtbl[lb]) begin
          if (mpv[k]) movr[k] = 1'b1;
          mpv[k] = 1; mpw[k] = {lb, rx_dat[23*k +: 23]};
        end else ndrop++;
      end else if (midle[k] < 1000000) midle[k]++;
    end
    mdrop = (mdrop + ndrop > 65535) ? 65535 : mdrop + ndrop;
    if (cfg_we) mtbl[cfg_lbl] = cfg_en;
  endfunction

  function automatic logic [NCH-1:0] mlost();
    logic [NCH-1:0] r;
    for (int k = 0; k < NCH; k++) r[k] = (midle[k] > LIM);
    return r;
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset(); else model_step();
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: per-cycle status against the model, output words against the queue.
  initial begin
    bit          pstall;
    logic [33:0] pout;
    wd_t         e;
    pstall = 0; pout = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin pstall = 0; continue; end
      chk("wr_en", wif.wr_en, mbusy);
      chk("ovr", ovr, movr);
      chk("lost", lost, mlost());
      chk("drop_cnt", drop_cnt, mdrop);
      if (pstall) chk("stall_stable", {wif.wr_ch, wif.wr_lbl, wif.wr_dat}, pout);
      if (wif.wr_en && wif.wr_rdy) begin
        if (exq.size() == 0) begin
          total++; bad++;
          $display("FAIL pop: output word ch=%0d with nothing expected", wif.wr_ch);
        end else begin
          e = exq.pop_front();
          chk("wr_ch", wif.wr_ch, e.ch);
          chk("wr_lbl", wif.wr_lbl, e.lbl);
          chk("wr_dat", wif.wr_dat, e.dat);
          ndeliv++;
        end
      end
      pstall = wif.wr_en && !wif.wr_rdy;
      pout   = {wif.wr_ch, wif.wr_lbl, wif.wr_dat};
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic set_ch(input int k, input logic [7:0] l, input logic [22:0] d);
    rx_adr[8*k +: 8] = l;
    rx_dat[23*k +: 23] = d;
  endtask

  task automatic strobe(input logic [NCH-1:0] m);
    rx_wr = m; tick(); rx_wr = '0;
  endtask

  task automatic cfg(input logic [7:0] l, input logic en);
    cfg_we = 1; cfg_lbl = l; cfg_en = en; tick(); cfg_we = 0;
  endtask

  int n0;

  initial begin
    wif.wr_rdy = 1'b0;
    repeat (3) tick();
    chk("rst_wr_en", wif.wr_en, 0);
    chk("rst_wr_ch", wif.wr_ch, 0);
    chk("rst_wr_lbl", wif.wr_lbl, 0);
    chk("rst_wr_dat", wif.wr_dat, 0);
    chk("rst_ovr", ovr, 0);
    chk("rst_lost", lost, 0);
    chk("rst_drop", drop_cnt, 0);
    rst_n = 1'b1;

    // single word through the pipe
    wif.wr_rdy = 1'b1;
    set_ch(0, 8'h31, 23'h12345);
    strobe(4'b0001);
    repeat (4) tick();
    chk("single_cnt", ndeliv, 1);

    // two simultaneous bursts on all channels
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < NCH; k++) set_ch(k, 8'h40 + 8'(k), 23'($urandom));
      strobe(4'b1111);
      repeat (10) tick();
      chk("burst_ovr", ovr, 0);
    end
    chk("burst_cnt", ndeliv, 9);

    // filtered label on two channels at once
    cfg(8'h55, 1'b0);
    set_ch(1, 8'h55, 23'h1); set_ch(2, 8'h55, 23'h2);
    strobe(4'b0110);
    repeat (3) tick();
    chk("filter_drop", drop_cnt, 2);
    chk("filter_cnt", ndeliv, 9);

    // stalled sink: A held on the output, B overwritten by C
    wif.wr_rdy = 1'b0;
    set_ch(2, 8'h10, 23'h0AAAA); strobe(4'b0100);
    repeat (3) tick();
    chk("stall_wr_en", wif.wr_en, 1);
    set_ch(2, 8'h11, 23'h0BBBB); strobe(4'b0100);
    set_ch(2, 8'h12, 23'h0CCCC); strobe(4'b0100);
    chk("stall_ovr", ovr, 4'b0100);
    repeat (5) tick();
    chk("stall_lbl_A", wif.wr_lbl, 8'h10);
    wif.wr_rdy = 1'b1;
    repeat (6) tick();
    chk("stall_cnt", ndeliv, 11);
    ovr_clr = 4'b0100; tick(); ovr_clr = '0;
    chk("ovr_clr", ovr, 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < NCH; k++) begin
        case ($urandom_range(0, 3))
          0: set_ch(k, 8'h55, 23'($urandom));
          1: set_ch(k, 8'h20, 23'($urandom));
          2: set_ch(k, 8'h21, 23'($urandom));
          default: set_ch(k, 8'($urandom), 23'($urandom));
        endcase
        rx_wr[k] = ($urandom_range(0, 3) == 0);
        ovr_clr[k] = ($urandom_range(0, 7) == 0);
      end
      cfg_we  = ($urandom_range(0, 15) == 0);
      cfg_en  = 1'($urandom);
      case ($urandom_range(0, 2))
        0: cfg_lbl = 8'h55;
        1: cfg_lbl = 8'h20;
        default: cfg_lbl = 8'h21;
      endcase
      wif.wr_rdy = ($urandom_range(0, 2) != 0);
      tick();
    end
    rx_wr = '0; ovr_clr = '0; cfg_we = 0; wif.wr_rdy = 1'b1;
    repeat (12) tick();
    chk("drain_empty", exq.size(), 0);

    // drop counter saturation
    cfg(8'h55, 1'b0);
    for (int k = 0; k < NCH; k++) set_ch(k, 8'h55, 23'h0);
    rx_wr = 4'b1111;
    repeat (16400) tick();
    rx_wr = '0;
    tick();
    chk("drop_sat", drop_cnt, 16'hFFFF);

    // reset in the middle of an issue
    wif.wr_rdy = 1'b0;
    cfg(8'h20, 1'b1);
    set_ch(0, 8'h20, 23'h777); strobe(4'b0001);
    repeat (3) tick();
    chk("pre_rst_wr_en", wif.wr_en, 1);
    n0 = ndeliv;
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("arst_wr_en", wif.wr_en, 0);
    chk("arst_ovr", ovr, 0);
    chk("arst_lost", lost, 0);
    chk("arst_drop", drop_cnt, 0);
    chk("arst_wr_lbl", wif.wr_lbl, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    wif.wr_rdy = 1'b1;
    tick();
    set_ch(1, 8'h55, 23'h555); rx_wr = 4'b0010;
    tick();
    rx_wr = '0;
    repeat (8) tick();
    @(negedge clk);
    chk("lost3_at10", lost[3], 0);
    @(negedge clk);
    chk("lost3_at11", lost[3], 1);
    set_ch(3, 8'h33, 23'h333); rx_wr = 4'b1000;
    @(negedge clk);
    rx_wr = '0;
    chk("lost3_fall", lost[3], 0);
    repeat (6) tick();
    chk("post_rst_cnt", ndeliv, n0 + 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ar_rx_sched.md
# ar_rx_sched

Receive scheduler for a bank of ARINC-429 word receivers. It captures each receiver's completed word (8-bit label, 23-bit data, write strobe) into a per-channel holding register and filters it against a configurable 256-entry label-enable table. Accepted words are arbitrated round-robin onto one shared valid/ready write port that feeds the label mailbox. The block also reports per-channel overrun and link-loss status, and counts filtered words.

## Interface
- `NCH`, 4: number of receive channels, 2..8.
- `CHW`, 3: width of `wr_ch`; must satisfy 2^CHW >= NCH.
- `LOST_LIM`, 60000: idle cycles without a word before a channel is flagged lost; 16-bit value, >0.
- `clk` in 1: system clock, all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `rx_adr` in NCH*8: label per channel; channel k occupies bits [8k+7:8k].
- `rx_dat` in NCH*23: data per channel; channel k occupies bits [23k+22:23k].
- `rx_wr` in NCH: one-cycle word-complete strobe per channel; `rx_adr`/`rx_dat` are valid in the same cycle.
- `cfg_we` in 1: label-table write strobe.
- `cfg_lbl` in 8: label-table address.
- `cfg_en` in 1: value written; 1 = label accepted.
- `wr_en` out 1: output word valid.
- `wr_rdy` in 1: sink ready.
- `wr_ch` out CHW: source channel of the output word.
- `wr_lbl` out 8: label of the output word.
- `wr_dat` out 23: data of the output word.
- `ovr` out NCH: sticky per-channel overrun flag.
- `ovr_clr` in NCH: per-channel overrun clear.
- `lost` out NCH: per-channel link-lost flag.
- `drop_cnt` out 16: saturating count of words rejected by the filter.

## Operation
- Label table: 256x1, all entries reset to 1. `cfg_we` writes `table[cfg_lbl] <= cfg_en`. A capture in the same cycle as a write uses the old entry value.
- Capture, per channel k, on `rx_wr[k]`:
  - If `table[label]` = 0, the word is discarded and the holding register is untouched.
  - Otherwise `hold[k]` <= {label, data} and `hv[k]` <= 1.
  - If `hv[k]` was already 1 and channel k is not granted this cycle, the old word is lost and `ovr[k]` <= 1.
- `drop_cnt` adds the number of channels rejected this cycle (0..NCH) and saturates at 0xFFFF.
- `ovr_clr[k]` clears `ovr[k]`. If a set and a clear hit the same channel in the same cycle, the set wins.
- Arbiter FSM, two states:
  - IDLE: if any `hv` is set, grant the first valid channel strictly after `ptr`, searching cyclically. The granted word is loaded into the output registers, `hv[g]` clears (unless `rx_wr[g]` recaptures it this cycle; no overrun in that case), `ptr` <= g, and the FSM goes to ISSUE.
  - ISSUE: `wr_en`=1 and the outputs are held stable. On `wr_rdy`=1 the transfer completes, `wr_en` <= 0, and the FSM returns to IDLE. There is no timeout.
- Link monitor, per channel: a 16-bit counter clears on `rx_wr[k]` (filtered or not), otherwise increments and saturates at `LOST_LIM`. `lost[k]` = (counter == `LOST_LIM`), registered.

## Timing
- Reset values:
  - outputs: `wr_en`=0, `wr_ch`/`wr_lbl`/`wr_dat`=0, `ovr`=0, `lost`=0, `drop_cnt`=0.
  - internal: `hv`=0, link counters=0, FSM=IDLE, `ptr`=NCH-1 (channel 0 wins first).
- Capture latency: `rx_wr` at edge n makes `hv` visible at n+1. Grant happens at n+1 and `wr_en` rises at n+2.
- Throughput: at most one word per 2 cycles (IDLE + ISSUE). The sink may stall indefinitely; holding registers absorb one word per channel, and further words overrun.
- `wr_en`/`wr_*` must not change while `wr_en`=1 and `wr_rdy`=0.
- `lost[k]` rises exactly `LOST_LIM`+1 cycles after the last `rx_wr[k]` (or after reset release) and falls one cycle after the next `rx_wr[k]`.
- Reset asserted mid-transfer drops the pending output word and all held words immediately. The label table also returns to all-1.

## Test plan
- Reset, then channel 0 strobes label 0x31 with data 0x12345 while `wr_rdy`=1 -> `wr_en` high for 1 cycle, 2 cycles after the strobe, carrying `wr_ch`=0, `wr_lbl`=0x31, `wr_dat`=0x12345.
- All 4 channels strobe in the same cycle, `wr_rdy`=1 -> output order is channel 0,1,2,3 at 2-cycle spacing, `ovr`=0. Repeat the burst -> order continues 0,1,2,3 from `ptr`=3.
- Write `cfg_lbl`=0x55, `cfg_en`=0, then channels 1 and 2 both strobe label 0x55 in one cycle -> no `wr_en`, `drop_cnt`=2. Force 0xFFFF+ drops -> `drop_cnt` holds 0xFFFF.
- Hold `wr_rdy`=0. Channel 2 strobes word A, then B, then C -> A is on the output and stable, B is overwritten by C, `ovr[2]`=1. Release `wr_rdy` -> A then C delivered. `ovr_clr[2]` -> `ovr[2]`=0.
- `LOST_LIM`=10, channel 3 idle after reset -> `lost[3]`=1 at cycle 11. A strobe on channel 3 -> `lost[3]`=0 next cycle.
- Assert `rst_n`=0 during ISSUE with `wr_rdy`=0 -> `wr_en`=0 immediately (asynchronous), all flags 0, and a previously disabled label is accepted again.
